// File: rtl/ps2_transceiver_pkg.sv
// Shared PS/2 definitions: FSM state encodings, protocol timing constants
// and the frame parity helper used by the transceiver.
package ps2_transceiver_pkg;

    localparam int PS2_INHIBIT_US  = 100;
    localparam int PS2_INHIBIT_DIV = 1_000_000 / PS2_INHIBIT_US;
    localparam int PS2_DATA_BITS   = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_INHIBIT,
        TX_REQ,
        TX_DATA,
        TX_PARITY,
        TX_STOP,
        TX_ACK,
        TX_WAITIDLE
    } tx_state_t;

    // Bit that makes the total count of ones across data+parity odd.
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Show-ahead scancode FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate count.
module ps2_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a push while full still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_transceiver.sv
// Bidirectional PS/2 host port: filtered device-to-host receive into a FIFO,
// host-to-device command send with ACK check, shared frame timeout.
module ps2_transceiver
    import ps2_transceiver_pkg::*;
#(
    parameter int CLK_HZ     = 28000000,
    parameter int FILTER_LEN = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT_MS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_i,
    input  logic       ps2data_i,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    input  logic       rcv_enable,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overflow,
    output logic       rx_parity_err,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int INHIBIT_CYC = CLK_HZ / PS2_INHIBIT_DIV;
    localparam int TO_CYC      = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int FW          = $clog2(FILTER_LEN);
    localparam int IW          = $clog2(INHIBIT_CYC + 1);
    localparam int TW          = $clog2(TO_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

    logic [1:0]    clk_sync, dat_sync;
    logic [FW-1:0] filt_cnt;
    logic          clk_filt, data_s, fall;

    assign data_s = dat_sync[1];

    // Lines idle high, so the synchronisers and filter reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2clk_i};
            dat_sync <= {dat_sync[0], ps2data_i};
            fall     <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= ~clk_sync[1];
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;
    logic [TW-1:0] to_cnt;
    logic          to_hit, tx_wait, rx_hold;

    assign tx_wait = (tx_state != TX_IDLE) && (tx_state != TX_INHIBIT);
    assign rx_hold = !rcv_enable || tx_busy;

    always_ff @(posedge clk) begin
        if (rst || fall || !(tx_wait || rx_state != RX_IDLE)) to_cnt <= '0;
        else                                                  to_cnt <= to_cnt + 1'b1;
    end
    assign to_hit = (tx_wait || rx_state != RX_IDLE) && (to_cnt == TO_LAST);

    logic [7:0] rx_sh;
    logic [2:0] rx_bit;
    logic       rx_par, rx_good, rx_push, rx_err_n;
    logic       fifo_full, fifo_empty, fifo_pop;

    assign rx_good = data_s && (^{rx_par, rx_sh});

    always_comb begin
        rx_next  = rx_state;
        rx_push  = 1'b0;
        rx_err_n = 1'b0;
        if (rx_hold) begin
            rx_next = RX_IDLE;
        end else if (fall) begin
            unique case (rx_state)
                RX_IDLE:   if (!data_s) rx_next = RX_DATA;
                RX_DATA:   if (rx_bit == 3'd7) rx_next = RX_PARITY;
                RX_PARITY: rx_next = RX_STOP;
                RX_STOP: begin
                    rx_next  = RX_IDLE;
                    rx_push  = rx_good;
                    rx_err_n = !rx_good;
                end
                default:   rx_next = RX_IDLE;
            endcase
        end else if (to_hit) begin
            rx_next = RX_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            rx_sh         <= '0;
            rx_bit        <= '0;
            rx_par        <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_state      <= rx_next;
            rx_parity_err <= rx_err_n;
            if (rx_state == RX_IDLE) rx_bit <= '0;
            if (fall && !rx_hold) begin
                if (rx_state == RX_DATA) begin
                    rx_sh  <= {data_s, rx_sh[7:1]};
                    rx_bit <= rx_bit + 1'b1;
                end
                if (rx_state == RX_PARITY) rx_par <= data_s;
            end
        end
    end

    assign rx_valid = !fifo_empty;
    assign fifo_pop = rx_ready && rx_valid;

    ps2_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_sh),
        .pop   (fifo_pop),
        .dout  (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst)                         rx_overflow <= 1'b0;
        else if (fifo_pop)               rx_overflow <= 1'b0;
        else if (rx_push && fifo_full)   rx_overflow <= 1'b1;
    end

    logic [7:0]    tx_sh;
    logic [2:0]    tx_bit;
    logic [IW-1:0] inh_cnt;
    logic          tx_par, data_oe, tx_nak, done_n, err_n;

    always_comb begin
        tx_next = tx_state;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (tx_state)
            TX_IDLE:     if (tx_load) tx_next = TX_INHIBIT;
            TX_INHIBIT:  if (inh_cnt == INH_LAST) tx_next = TX_REQ;
            TX_REQ:      if (fall) tx_next = TX_DATA;
            TX_DATA:     if (fall && tx_bit == 3'd6) tx_next = TX_PARITY;
            TX_PARITY:   if (fall) tx_next = TX_STOP;
            TX_STOP:     if (fall) tx_next = TX_ACK;
            TX_ACK:      if (fall) tx_next = TX_WAITIDLE;
            TX_WAITIDLE: if (clk_filt && data_s) begin
                tx_next = TX_IDLE;
                done_n  = 1'b1;
                err_n   = tx_nak;
            end
            default:     tx_next = TX_IDLE;
        endcase
        if (tx_wait && to_hit) begin
            tx_next = TX_IDLE;
            done_n  = 1'b1;
            err_n   = 1'b1;
        end
    end

    // Each fall hands the line the next bit; the device samples it on the rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_par   <= 1'b0;
            inh_cnt  <= '0;
            data_oe  <= 1'b0;
            tx_nak   <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_done  <= done_n;
            tx_error <= err_n;
            inh_cnt  <= (tx_state == TX_INHIBIT) ? inh_cnt + 1'b1 : '0;
            if (tx_state == TX_IDLE && tx_load) begin
                tx_sh  <= tx_data;
                tx_par <= odd_parity(tx_data);
                tx_bit <= '0;
            end
            if (tx_next == TX_IDLE) begin
                data_oe <= 1'b0;
            end else if (tx_state == TX_INHIBIT && tx_next == TX_REQ) begin
                data_oe <= 1'b1;
            end else if (fall) begin
                case (tx_state)
                    TX_REQ:    data_oe <= ~tx_sh[0];
                    TX_DATA: begin
                        data_oe <= ~tx_sh[1];
                        tx_sh   <= tx_sh >> 1;
                        tx_bit  <= tx_bit + 1'b1;
                    end
                    TX_PARITY: data_oe <= ~tx_par;
                    TX_STOP:   data_oe <= 1'b0;
                    TX_ACK:    tx_nak  <= data_s;
                    default:   ;
                endcase
            end
        end
    end

    assign tx_busy    = (tx_state != TX_IDLE);
    assign ps2clk_oe  = (tx_state == TX_INHIBIT);
    assign ps2data_oe = data_oe;

endmodule

// File: tb/tb_ps2_transceiver.sv
// Randomised bench: a behavioural PS/2 device drives the open-drain lines and a
// queue model of the FIFO supplies every expected value.
module tb_ps2_transceiver;
    localparam int CLK_HZ      = 1_000_000;
    localparam int FILTER_LEN  = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_MS  = 2;
    localparam int INHIBIT_CYC = CLK_HZ / 10000;
    localparam int TO_CYC      = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int HALF        = 25;

    logic       clk = 1'b0, rst = 1'b1;
    logic       dev_clk = 1'b1, dev_data = 1'b1;
    logic       rcv_enable = 1'b1, rx_ready = 1'b0, tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ps2clk_i, ps2data_i, ps2clk_oe, ps2data_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_overflow, rx_parity_err, tx_busy, tx_done, tx_error;

    assign ps2clk_i  = dev_clk & ~ps2clk_oe;
    assign ps2data_i = dev_data & ~ps2data_oe;

    ps2_transceiver #(
        .CLK_HZ(CLK_HZ), .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk(clk), .rst(rst), .ps2clk_i(ps2clk_i), .ps2data_i(ps2data_i),
        .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe), .rcv_enable(rcv_enable),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .rx_parity_err(rx_parity_err),
        .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0, n_err = 0;
    int   perr_seen = 0, done_seen = 0;
    logic last_err = 1'b0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    always @(negedge clk) begin
        if (rx_parity_err === 1'b1) perr_seen++;
        if (tx_done === 1'b1) begin
            done_seen++;
            last_err = tx_error;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
        else                           exp_ovf = 1'b1;
    endtask

    task automatic model_pop();
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_ovf = 1'b0;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    // Device-to-host frame; glitch_at puts a short low pulse inside that bit's high phase.
    task automatic dev_send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_at);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_data = fr[i];
            if (i == glitch_at) begin
                wait_cyc(8); dev_clk = 1'b0; wait_cyc(3); dev_clk = 1'b1; wait_cyc(HALF - 11);
            end else begin
                wait_cyc(HALF);
            end
            dev_clk = 1'b0;
            wait_cyc(HALF);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic dev_partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            dev_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            wait_cyc(HALF); dev_clk = 1'b0; wait_cyc(HALF); dev_clk = 1'b1;
        end
        dev_data = 1'b1;
        wait_cyc(HALF);
    endtask

    // Host-to-device: device clocks 11 falls, reads each bit late in the low phase.
    task automatic dev_recv(input bit ack, output logic [10:0] bits);
        bits[0] = ps2data_i;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) dev_data = 1'b0;
            wait_cyc(HALF);
            dev_clk = 1'b0;
            wait_cyc(HALF);
            if (i <= 10) bits[i] = ps2data_i;
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(4);
        n_cmp++; if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0) begin n_err++;
            $display("FAIL reset_oe: got clk_oe=%b data_oe=%b expected 0 0", ps2clk_oe, ps2data_oe); end
        n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_overflow !== 1'b0 || rx_parity_err !== 1'b0) begin n_err++;
            $display("FAIL reset_rx: got valid=%b data=%h ovf=%b perr=%b expected 0 00 0 0", rx_valid, rx_data, rx_overflow, rx_parity_err); end
        n_cmp++; if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_error !== 1'b0) begin n_err++;
            $display("FAIL reset_tx: got busy=%b done=%b err=%b expected 0 0 0", tx_busy, tx_done, tx_error); end
        rst = 1'b0;
        wait_cyc(20);
        n_cmp++; if (rx_valid !== 1'b0 || tx_busy !== 1'b0 || ps2clk_oe !== 1'b0) begin n_err++;
            $display("FAIL reset_idle: got valid=%b busy=%b clk_oe=%b expected 0 0 0", rx_valid, tx_busy, ps2clk_oe); end
    endtask

    task automatic test_rx_random();
        logic [7:0] b;
        int p0;
        for (int k = 0; k < 4; k++) begin
            b  = (k == 0) ? 8'h1C : 8'($urandom_range(0, 255));
            p0 = perr_seen;
            dev_send(b, 0, 0, -1);
            model_push(b);
            n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp_q[0]) begin n_err++;
                $display("FAIL rx_byte: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp_q[0]); end
            n_cmp++; if (perr_seen != p0) begin n_err++;
                $display("FAIL rx_no_err: got %0d error pulses expected 0", perr_seen - p0); end
            pop_one();
            model_pop();
            n_cmp++; if (rx_valid !== 1'b0) begin n_err++;
                $display("FAIL rx_drained: got valid=%b expected 0", rx_valid); end
        end
    endtask

    task automatic test_bad_frames();
        int p0;
        p0 = perr_seen;
        dev_send(8'h1C, 1, 0, -1);
        dev_send(8'h1C, 0, 1, -1);
        n_cmp++; if (perr_seen != p0 + 2 || rx_valid !== 1'b0) begin n_err++;
            $display("FAIL bad_frames: got %0d pulses valid=%b expected 2 0", perr_seen - p0, rx_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom_range(0, 255));
            dev_send(b, 0, 0, -1);
            model_push(b);
        end
        n_cmp++; if (rx_overflow !== exp_ovf) begin n_err++;
            $display("FAIL ovf_set: got %b expected %b", rx_overflow, exp_ovf); end
        n_cmp++; if (rx_data !== exp_q[0]) begin n_err++;
            $display("FAIL ovf_head: got %h expected %h", rx_data, exp_q[0]); end
        pop_one();
        model_pop();
        n_cmp++; if (rx_overflow !== exp_ovf || rx_data !== exp_q[0]) begin n_err++;
            $display("FAIL ovf_pop: got ovf=%b head=%h expected %b %h", rx_overflow, rx_data, exp_ovf, exp_q[0]); end
        while (exp_q.size() > 0) begin
            n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp_q[0]) begin n_err++;
                $display("FAIL ovf_drain: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp_q[0]); end
            pop_one();
            model_pop();
        end
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++;
            $display("FAIL ovf_empty: got valid=%b expected 0", rx_valid); end
    endtask

    task automatic test_tx(input bit ack, input logic [7:0] b);
        logic [10:0] bits, exp_fr;
        int n, d0;
        d0 = done_seen;
        exp_fr = {1'b1, ~^b, b, 1'b0};
        tx_data = b; tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        n_cmp++; if (tx_busy !== 1'b1 || ps2clk_oe !== 1'b1) begin n_err++;
            $display("FAIL tx_start: got busy=%b clk_oe=%b expected 1 1", tx_busy, ps2clk_oe); end
        n = 0;
        while (ps2clk_oe === 1'b1 && n < 10 * INHIBIT_CYC) begin n++; tick(); end
        n_cmp++; if (n != INHIBIT_CYC) begin n_err++;
            $display("FAIL tx_inhibit: got %0d cycles expected %0d", n, INHIBIT_CYC); end
        n_cmp++; if (ps2data_oe !== 1'b1) begin n_err++;
            $display("FAIL tx_req: got data_oe=%b expected 1", ps2data_oe); end
        dev_recv(ack, bits);
        n_cmp++; if (bits !== exp_fr) begin n_err++;
            $display("FAIL tx_frame: got %b expected %b", bits, exp_fr); end
        n = 0;
        while (done_seen == d0 && n < 400) begin tick(); n++; end
        n_cmp++; if (done_seen != d0 + 1 || last_err !== ~ack) begin n_err++;
            $display("FAIL tx_result: got %0d done err=%b expected 1 %b", done_seen - d0, last_err, ~ack); end
        n_cmp++; if (tx_busy !== 1'b0 || ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0) begin n_err++;
            $display("FAIL tx_release: got busy=%b clk_oe=%b data_oe=%b expected 0 0 0", tx_busy, ps2clk_oe, ps2data_oe); end
    endtask

    task automatic test_tx_timeout();
        int n;
        tx_data = 8'($urandom_range(0, 255)); tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        n = 0;
        while (ps2clk_oe === 1'b1 && n < 1000) begin n++; tick(); end
        n = 0;
        while (tx_done !== 1'b1 && n < 3 * TO_CYC) begin tick(); n++; end
        n_cmp++; if (n < TO_CYC - 1 || n > TO_CYC + 1) begin n_err++;
            $display("FAIL tx_timeout_len: got %0d cycles expected %0d", n, TO_CYC); end
        n_cmp++; if (tx_done !== 1'b1 || tx_error !== 1'b1 || ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0) begin n_err++;
            $display("FAIL tx_timeout: got done=%b err=%b clk_oe=%b data_oe=%b expected 1 1 0 0", tx_done, tx_error, ps2clk_oe, ps2data_oe); end
        wait_cyc(5);
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        int p0;
        b  = 8'($urandom_range(0, 255));
        p0 = perr_seen;
        dev_send(b, 0, 0, 1 + int'($urandom_range(0, 8)));
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== b || perr_seen != p0) begin n_err++;
            $display("FAIL glitch: got valid=%b data=%h pulses=%0d expected 1 %h 0", rx_valid, rx_data, perr_seen - p0, b); end
        if (rx_valid === 1'b1) pop_one();
    endtask

    task automatic test_rcv_disable();
        rcv_enable = 1'b0;
        dev_send(8'($urandom_range(0, 255)), 0, 0, -1);
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++;
            $display("FAIL rcv_disable: got valid=%b expected 0", rx_valid); end
        rcv_enable = 1'b1;
    endtask

    task automatic test_rx_timeout();
        logic [7:0] b;
        int p0;
        b  = 8'($urandom_range(0, 255));
        p0 = perr_seen;
        dev_partial(3);
        wait_cyc(TO_CYC + 50);
        dev_send(b, 0, 0, -1);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== b || perr_seen != p0) begin n_err++;
            $display("FAIL rx_timeout: got valid=%b data=%h pulses=%0d expected 1 %h 0", rx_valid, rx_data, perr_seen - p0, b); end
        if (rx_valid === 1'b1) pop_one();
    endtask

    task automatic test_interlock();
        logic [7:0] b;
        int p0;
        p0 = perr_seen;
        dev_partial(4);
        test_tx(1, 8'($urandom_range(0, 255)));
        n_cmp++; if (rx_valid !== 1'b0 || perr_seen != p0) begin n_err++;
            $display("FAIL interlock_abort: got valid=%b pulses=%0d expected 0 0", rx_valid, perr_seen - p0); end
        b = 8'($urandom_range(0, 255));
        dev_send(b, 0, 0, -1);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== b) begin n_err++;
            $display("FAIL interlock_recover: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, b); end
        if (rx_valid === 1'b1) pop_one();
    endtask

    task automatic test_reset_mid_tx();
        int d0;
        d0 = done_seen;
        tx_data = 8'($urandom_range(0, 255)); tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        wait_cyc(INHIBIT_CYC + 5);
        n_cmp++; if (ps2data_oe !== 1'b1) begin n_err++;
            $display("FAIL rst_pre: got data_oe=%b expected 1", ps2data_oe); end
        rst = 1'b1;
        tick();
        n_cmp++; if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b0 || tx_busy !== 1'b0) begin n_err++;
            $display("FAIL rst_mid_tx: got clk_oe=%b data_oe=%b busy=%b expected 0 0 0", ps2clk_oe, ps2data_oe, tx_busy); end
        tick();
        rst = 1'b0;
        wait_cyc(20);
        n_cmp++; if (done_seen != d0) begin n_err++;
            $display("FAIL rst_no_done: got %0d done pulses expected 0", done_seen - d0); end
    endtask

    initial begin
        test_reset();
        test_rx_random();
        test_bad_frames();
        test_overflow();
        test_tx(1, 8'hED);
        test_tx(1, 8'($urandom_range(0, 255)));
        test_tx(0, 8'($urandom_range(0, 255)));
        test_tx_timeout();
        test_glitch();
        test_rcv_disable();
        test_rx_timeout();
        test_interlock();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
